// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: data-memory request/response handshake, upstream stall and MEM/WB register.
// Optional alignment check enabled by defining MEM_ALIGN_CHK_EN.
module mem_stage_ctrl #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   mem_alu_result,
    input  logic [XLEN-1:0]   mem_rs2_val,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_mem_read,
    input  logic              mem_mem_write,
    input  logic              mem_reg_write,
    input  logic              mem_mem_to_reg,
    input  logic              mem_jal,
    input  logic [XLEN-1:0]   mem_pc_plus4,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              mem_stall,
    output logic [XLEN-1:0]   wb_wdata,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_reg_write,
    output logic              mem_misalign
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t            r_state;
    logic              r_dmem_req;
    logic              r_dmem_we;
    logic [XLEN-1:0]   r_dmem_addr;
    logic [XLEN-1:0]   r_dmem_wdata;
    logic [XLEN-1:0]   r_wb_wdata;
    logic [REG_AW-1:0] r_wb_rd;
    logic              r_wb_reg_write;

    logic w_acc;
    logic w_misal;
    logic w_done;
    logic w_load_done;
    logic w_stall;
    logic w_unused_mem_to_reg;

    assign w_acc = mem_mem_read | mem_mem_write;
    // Load data selection is driven by load completion, so mem_to_reg carries no extra information.
    assign w_unused_mem_to_reg = mem_mem_to_reg;

`ifdef MEM_ALIGN_CHK_EN
    logic r_misalign;

    assign w_misal = (r_state == S_IDLE) && w_acc && (mem_alu_result[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misal;
        end
    end

    assign mem_misalign = r_misalign;
`else
    assign w_misal      = 1'b0;
    assign mem_misalign = 1'b0;
`endif

    always_comb begin
        w_done      = 1'b0;
        w_load_done = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = w_acc & ~w_misal;
            end
            S_REQ: begin
                if (dmem_gnt) begin
                    if (r_dmem_we) begin
                        w_done = 1'b1;
                    end else if (dmem_rvalid) begin
                        w_done      = 1'b1;
                        w_load_done = 1'b1;
                    end
                end
                w_stall = ~w_done;
            end
            S_RESP: begin
                w_done      = dmem_rvalid;
                w_load_done = dmem_rvalid;
                w_stall     = ~dmem_rvalid;
            end
            default: begin
                w_stall = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_dmem_req     <= 1'b0;
            r_dmem_we      <= 1'b0;
            r_dmem_addr    <= '0;
            r_dmem_wdata   <= '0;
            r_wb_wdata     <= '0;
            r_wb_rd        <= '0;
            r_wb_reg_write <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc && !w_misal) begin
                        r_dmem_req   <= 1'b1;
                        r_dmem_we    <= mem_mem_write;
                        r_dmem_addr  <= mem_alu_result;
                        r_dmem_wdata <= mem_rs2_val;
                        r_state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (dmem_gnt) begin
                        r_dmem_req <= 1'b0;
                        r_state    <= w_done ? S_IDLE : S_RESP;
                    end
                end
                S_RESP: begin
                    if (dmem_rvalid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // A stalled cycle inserts a bubble; data and destination keep their last values.
            if (w_stall) begin
                r_wb_reg_write <= 1'b0;
            end else begin
                r_wb_rd        <= mem_rd;
                r_wb_reg_write <= mem_reg_write & ~w_misal;
                r_wb_wdata     <= w_load_done ? dmem_rdata :
                                  mem_jal     ? mem_pc_plus4 : mem_alu_result;
            end
        end
    end

    assign dmem_req     = r_dmem_req;
    assign dmem_we      = r_dmem_we;
    assign dmem_addr    = r_dmem_addr;
    assign dmem_wdata   = r_dmem_wdata;
    assign mem_stall    = w_stall;
    assign wb_wdata     = r_wb_wdata;
    assign wb_rd        = r_wb_rd;
    assign wb_reg_write = r_wb_reg_write;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: per-instruction occupancy model checked every cycle, plus directed
// reset/abandon sequences and literal expectations. Define MEM_ALIGN_CHK_EN to cover the checked build.
module tb_mem_stage_ctrl;

    localparam int N = 10;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        jal;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [31:0] pc4;
        int          gw;
        int          rdl;
        logic [31:0] rdata;
        logic        stray;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_alu_result, mem_rs2_val, mem_pc_plus4;
    logic [4:0]  mem_rd;
    logic        mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg, mem_jal;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        mem_stall;
    logic [31:0] wb_wdata;
    logic [4:0]  wb_rd;
    logic        wb_reg_write, mem_misalign;

    mem_stage_ctrl #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset),
        .mem_alu_result(mem_alu_result), .mem_rs2_val(mem_rs2_val), .mem_rd(mem_rd),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_jal(mem_jal), .mem_pc_plus4(mem_pc_plus4),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .wb_wdata(wb_wdata),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .mem_misalign(mem_misalign)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_err    = 0;
    vec_t prog [N];
    vec_t nop;
    int   cur_idx  = 0;
    int   cur_k    = 0;
    bit   running  = 1'b0;

    int          stall_cnt [N];
    int          req_cnt   [N];
    logic [31:0] req_addr  [N];
    logic [31:0] wlog_data [16];
    logic [4:0]  wlog_rd   [16];
    int          wlog_n    = 0;
    int          mis_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] rd, input logic rw, input logic mr,
                                input logic mw, input logic jal, input logic [31:0] alu,
                                input logic [31:0] rs2, input logic [31:0] pc4, input int gw,
                                input int rdl, input logic [31:0] rdata, input logic stray);
        vec_t v;
        v.rd = rd; v.rw = rw; v.mr = mr; v.mw = mw; v.jal = jal; v.alu = alu;
        v.rs2 = rs2; v.pc4 = pc4; v.gw = gw; v.rdl = rdl; v.rdata = rdata; v.stray = stray;
        return v;
    endfunction

    function automatic bit is_acc(input vec_t v);
        return bit'(v.mr | v.mw);
    endfunction

    function automatic bit is_mis(input vec_t v);
`ifdef MEM_ALIGN_CHK_EN
        return is_acc(v) && (v.alu[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_mem(input vec_t v);
        return is_acc(v) && !is_mis(v);
    endfunction

    function automatic bit is_load(input vec_t v);
        return bit'(v.mr & ~v.mw);
    endfunction

    // Cycles an instruction spends in MEM: issue, wait cycles, grant, then response wait for loads.
    function automatic int occ(input vec_t v);
        if (!is_mem(v)) return 1;
        return 2 + v.gw + (is_load(v) ? v.rdl : 0);
    endfunction

    function automatic vec_t cur_vec();
        return (cur_idx < N) ? prog[cur_idx] : nop;
    endfunction

    task automatic drive();
        vec_t v;
        bit   real_rv;
        v = cur_vec();
        mem_alu_result = v.alu;  mem_rs2_val   = v.rs2;  mem_pc_plus4  = v.pc4;
        mem_rd         = v.rd;   mem_mem_read  = v.mr;   mem_mem_write = v.mw;
        mem_reg_write  = v.rw;   mem_mem_to_reg = v.mr;  mem_jal       = v.jal;
        dmem_gnt = is_mem(v) && (cur_k == 1 + v.gw);
        real_rv  = is_mem(v) && is_load(v) && (cur_k == 1 + v.gw + v.rdl);
        dmem_rvalid = real_rv || (v.stray && is_mem(v) && cur_k <= v.gw);
        dmem_rdata  = real_rv ? v.rdata : (32'hBAD0_0000 | 32'(cur_k));
    endtask

    logic        exp_wbv  = 1'b0;
    logic [4:0]  exp_rd   = '0;
    logic [31:0] exp_data = '0;
    logic        exp_mis  = 1'b0;

    always @(negedge clk) begin
        if (running) begin
            vec_t v;
            int   k;
            v = cur_vec();
            k = cur_k;
            chk("stall", 32'(mem_stall), 32'(k < occ(v) - 1));
            chk("req", 32'(dmem_req), 32'(is_mem(v) && k >= 1 && k <= 1 + v.gw));
            if (dmem_req) begin
                chk("req_addr", dmem_addr, v.alu);
                chk("req_we", 32'(dmem_we), 32'(v.mw));
                chk("req_wdata", dmem_wdata, v.rs2);
            end
            chk("wb_we", 32'(wb_reg_write), 32'(exp_wbv));
            if (exp_wbv) begin
                chk("wb_rd", 32'(wb_rd), 32'(exp_rd));
                chk("wb_wdata", wb_wdata, exp_data);
            end
            chk("misalign", 32'(mem_misalign), 32'(exp_mis));

            if (cur_idx < N) begin
                if (mem_stall) stall_cnt[cur_idx]++;
                if (dmem_req) begin
                    req_cnt[cur_idx]++;
                    req_addr[cur_idx] = dmem_addr;
                end
            end
            if (wb_reg_write && wlog_n < 16) begin
                wlog_rd[wlog_n]   = wb_rd;
                wlog_data[wlog_n] = wb_wdata;
                wlog_n++;
            end
            if (mem_misalign) mis_cnt++;

            exp_wbv  = (k == occ(v) - 1) && v.rw && !is_mis(v);
            exp_rd   = v.rd;
            exp_data = (is_mem(v) && is_load(v)) ? v.rdata : (v.jal ? v.pc4 : v.alu);
            exp_mis  = is_mis(v);
        end
    end

    initial begin
        nop = mk(5'd0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
        prog[0] = mk(5'd5, 1, 0, 0, 0, 32'h0000_1234, 32'h0,      32'h0,  0, 0, 32'h0,         0);
        prog[1] = mk(5'd1, 1, 0, 0, 1, 32'h0000_0999, 32'h0,      32'h44, 0, 0, 32'h0,         0);
        prog[2] = mk(5'd7, 1, 1, 0, 0, 32'h0000_0100, 32'h0,      32'h0,  2, 1, 32'hDEADBEEF,  1);
        prog[3] = mk(5'd0, 0, 0, 1, 0, 32'h0000_0200, 32'hCAFE,   32'h0,  0, 0, 32'h0,         0);
        prog[4] = mk(5'd0, 0, 0, 1, 0, 32'h0000_0204, 32'hBEEF,   32'h0,  0, 0, 32'h0,         0);
        prog[5] = mk(5'd9, 1, 1, 0, 0, 32'h0000_0300, 32'h0,      32'h0,  0, 0, 32'h1111_2222, 0);
        prog[6] = mk(5'd3, 1, 1, 1, 0, 32'h0000_0208, 32'h77,     32'h0,  1, 0, 32'h0,         0);
        prog[7] = mk(5'd4, 1, 1, 0, 0, 32'h0000_0102, 32'h0,      32'h0,  1, 2, 32'h0000_ABCD, 0);
        prog[8] = mk(5'd2, 1, 0, 0, 0, 32'h0000_0055, 32'h0,      32'h0,  0, 0, 32'h0,         0);
        prog[9] = mk(5'd6, 1, 1, 0, 0, 32'h0000_0400, 32'h0,      32'h0,  0, 3, 32'h0000_0F0F, 1);
        for (int i = 0; i < N; i++) begin
            stall_cnt[i] = 0; req_cnt[i] = 0; req_addr[i] = '0;
        end

        // Reset held with an eager memory: nothing may come out.
        reset = 1'b1;
        drive();
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset_ctrl", {28'd0, dmem_req, dmem_we, mem_stall, mem_misalign}, 32'h0);
            chk("reset_addr", dmem_addr | dmem_wdata, 32'h0);
            chk("reset_wb", wb_wdata | {26'd0, wb_rd, wb_reg_write}, 32'h0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cur_idx = 0; cur_k = 0;
        drive();
        running = 1'b1;

        while (cur_idx < N + 2) begin
            vec_t v;
            @(posedge clk);
            #1;
            v = cur_vec();
            if (cur_k >= occ(v) - 1) begin
                cur_idx++;
                cur_k = 0;
            end else begin
                cur_k++;
            end
            drive();
        end
        running = 1'b0;

        chk("lit_alu_wb", {wlog_rd[0], wlog_data[0][26:0]}, {5'd5, 27'h1234});
        chk("lit_jal_wb", {wlog_rd[1], wlog_data[1][26:0]}, {5'd1, 27'h44});
        chk("lit_load_wb", wlog_data[2], 32'hDEADBEEF);
        chk("lit_both_is_store", wlog_data[4], 32'h0000_0208);
        chk("lit_load_stall", 32'(stall_cnt[2]), 32'd4);
        chk("lit_alu_nostall", 32'(stall_cnt[0] + stall_cnt[1]), 32'd0);
        chk("lit_store_req", 32'(req_cnt[3]), 32'd1);
        chk("lit_store_stall", 32'(stall_cnt[3]), 32'd1);
`ifdef MEM_ALIGN_CHK_EN
        chk("lit_wb_count", 32'(wlog_n), 32'd7);
        chk("lit_mis_req", 32'(req_cnt[7] + stall_cnt[7]), 32'd0);
        chk("lit_mis_pulse", 32'(mis_cnt), 32'd1);
`else
        chk("lit_wb_count", 32'(wlog_n), 32'd8);
        chk("lit_mis_addr", req_addr[7], 32'h0000_0102);
        chk("lit_mis_pulse", 32'(mis_cnt), 32'd0);
`endif

        // Reset while waiting for load data abandons the access.
        mem_mem_read = 1'b1; mem_mem_write = 1'b0; mem_alu_result = 32'h500;
        mem_rd = 5'd8; mem_reg_write = 1'b1; mem_jal = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        @(posedge clk); #1;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(negedge clk);
        chk("resp_stall", 32'(mem_stall), 32'd1);
        chk("resp_req", 32'(dmem_req), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mem_mem_read = 1'b0; mem_reg_write = 1'b0; mem_rd = 5'd0; mem_alu_result = 32'h0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("abandon_req", 32'(dmem_req), 32'd0);
            chk("abandon_stall", 32'(mem_stall), 32'd0);
            chk("abandon_wb", 32'(wb_reg_write), 32'd0);
            @(posedge clk); #1;
        end
        dmem_rvalid = 1'b0;
        mem_alu_result = 32'h77; mem_rd = 5'd10; mem_reg_write = 1'b1;
        @(posedge clk); #1;
        mem_reg_write = 1'b0;
        @(negedge clk);
        chk("post_reset_wb", {wb_reg_write, 26'd0, wb_rd}, {1'b1, 26'd0, 5'd10});
        chk("post_reset_data", wb_wdata, 32'h77);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
